// File: rtl/pipe_hazard_ctrl.sv
// ID->EX hazard control: scoreboard of in-flight writes, RAW stall, flush bubble, halt/drain FSM.
// Outputs are combinational from state and ID inputs; define FORWARDING_EN to forward hits on entries >=1.
module pipe_hazard_ctrl #(
   parameter int DEPTH  = 3,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16,
   localparam int PW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_wb,
   input  logic [ADDR_W-1:0] id_dst_addr,
   input  logic [ADDR_W-1:0] id_src_addr,
   input  logic [ADDR_W-1:0] id_tar_addr,
   input  logic              id_src_used,
   input  logic              id_tar_used,
   input  logic              flush,
   input  logic              halt_req,
   output logic              stall,
   output logic              bubble,
   output logic              halted,
   output logic [PW-1:0]     pend_cnt,
   output logic [CNT_W-1:0]  stall_cnt
`ifdef FORWARDING_EN
   ,
   output logic [PW-1:0]     fwd_src_sel,
   output logic [PW-1:0]     fwd_tar_sel
`endif
);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t            state_q, state_d;
   logic [DEPTH-1:0]  vld_q;
   logic [ADDR_W-1:0] dst_q [DEPTH];
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [DEPTH-1:0]  hit_src, hit_tar;
   logic              hazard;
   logic              run;
   logic              issue;
   logic [PW-1:0]     pend;

   always_comb begin
      hit_src = '0;
      hit_tar = '0;
      pend    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_src[i] = vld_q[i] && (dst_q[i] == id_src_addr) && id_src_used && (id_src_addr != '0);
         hit_tar[i] = vld_q[i] && (dst_q[i] == id_tar_addr) && id_tar_used && (id_tar_addr != '0);
         pend       = pend + PW'(vld_q[i]);
      end
   end

`ifdef FORWARDING_EN
   logic [PW-1:0] src_sel, tar_sel;

   // Walk oldest to youngest so the youngest producer with a result wins.
   always_comb begin
      src_sel = '0;
      tar_sel = '0;
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (hit_src[k]) src_sel = PW'(k);
         if (hit_tar[k]) tar_sel = PW'(k);
      end
      hazard = hit_src[0] | hit_tar[0];
   end

   assign fwd_src_sel = src_sel;
   assign fwd_tar_sel = tar_sel;
`else
   assign hazard = (|hit_src) | (|hit_tar);
`endif

   assign run      = (state_q == RUN);
   assign stall    = (id_valid & hazard & ~flush & run) | ~run;
   assign bubble   = flush | stall;
   assign halted   = (state_q == HALTED);
   assign issue    = id_valid & ~stall & ~flush & run;
   assign pend_cnt = pend;
   assign stall_cnt = cnt_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (halt_req) state_d = DRAIN;
         DRAIN:   if (!halt_req) state_d = RUN;
                  else if (pend == '0) state_d = HALTED;
         HALTED:  if (!halt_req) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         vld_q   <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < DEPTH; i++) dst_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vld_q   <= {vld_q[DEPTH-2:0], issue & id_wb & (id_dst_addr != '0)};
         dst_q[0] <= id_dst_addr;
         for (int i = 1; i < DEPTH; i++) dst_q[i] <= dst_q[i-1];
      end
   end

endmodule
